piece_ctrl: RTL and testbench
=============================

Name: piece_ctrl

Overview:
- Active-piece controller for the Tetris datapath: holds anchor X/Y and rotation of the falling piece.
- Arbitrates player commands against an internal gravity timer.
- Validates every candidate move through a request/acknowledge handshake with the external board collision checker.
- Sequences lock, respawn and game-over.
- Parametrised successor to the unchecked position counter: adds bounds limits, rotation modulus, gravity and lock/spawn sequencing.

Parameters:
- X_W, 5, width of X coordinate.
- Y_W, 5, width of Y coordinate.
- ROT_W, 2, width of rotation index.
- ROT_STATES, 4, number of rotation states; rotation wraps modulo this value (≤ 2^ROT_W).
- BOARD_W, 10, board columns; legal anchor X is 0..BOARD_W-1.
- BOARD_H, 20, board rows; legal anchor Y is 0..BOARD_H-1.
- SPAWN_X, 4, anchor X at spawn.
- SPAWN_Y, 0, anchor Y at spawn.
- GRAV_DIV, 50000000, clk cycles per gravity step (≥ 2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- err  in  1  synchronous active-high reset.
- drop  in  1  soft-drop request, level sampled in IDLE.
- left  in  1  move-left request.
- right  in  1  move-right request.
- ro  in  1  rotate-clockwise request.
- chk_ack  in  1  collision checker result valid.
- chk_hit  in  1  candidate collides, qualified by chk_ack.
- block_pos_x_out  out  X_W  committed anchor X.
- block_pos_y_out  out  Y_W  committed anchor Y.
- rotate  out  ROT_W  committed rotation index.
- chk_req  out  1  candidate valid, held until chk_ack.
- cand_x  out  X_W  candidate X.
- cand_y  out  Y_W  candidate Y.
- cand_rot  out  ROT_W  candidate rotation.
- busy  out  1  high in any state other than IDLE.
- lock_pulse  out  1  one-cycle strobe; board latches the piece at committed position/rotation.
- game_over  out  1  sticky, cleared only by err.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values (err=1): X=SPAWN_X, Y=SPAWN_Y, rotate=0; chk_req, lock_pulse, game_over, busy = 0; cand_* = committed values; gravity counter = 0; gravity pending = 0; state = IDLE.
- err overrides every state, including mid-handshake. chk_req drops on the cycle after err is sampled. Any late chk_ack is ignored.
- Gravity counter: counts 0..GRAV_DIV-1 continuously except in OVER. On wrap it sets grav_pend, a single flag that does not accumulate. grav_pend is cleared when a drop-type request is launched, from either soft drop or gravity.
- Command priority, sampled only in IDLE: (drop | grav_pend) > left > right > ro. Commands seen while busy are discarded; there is no queue.
- Bounds pre-check in IDLE, with no handshake:
  - left at X=0, or right at X=BOARD_W-1: command dropped, stay IDLE.
  - drop at Y=BOARD_H-1: go straight to LOCK.
- States:
  - IDLE: on an accepted command, load cand_* with the move (X-1, X+1, Y+1, or (rot+1) mod ROT_STATES) and go to CHECK.
  - CHECK: chk_req=1 and cand_* stable until chk_ack. On the ack cycle:
    - hit=0: commit cand_* to the outputs at that edge, go to IDLE.
    - hit=1 on move/rotate: discard, go to IDLE.
    - hit=1 on drop: go to LOCK.
  - LOCK: lock_pulse=1 for exactly one cycle with outputs unchanged, then go to SPAWN.
  - SPAWN: commit X=SPAWN_X, Y=SPAWN_Y, rot=0. cand_* = spawn values, chk_req=1. On ack:
    - hit=0: go to IDLE.
    - hit=1: go to OVER.
  - OVER: game_over=1, commands and gravity ignored, outputs frozen until err.
- Latency:
  - Accepted command with ack in the same cycle as chk_req assertion: committed outputs update 2 edges after the command is sampled.
  - Minimum time from drop-hit to piece respawned: 4 cycles.
- Arithmetic: all coordinate math is unsigned. The pre-check guarantees no underflow or overflow. Rotation wraps ROT_STATES-1 → 0.
- Simultaneous inputs: gravity wrap in the same cycle as a player drop yields one Y step only. grav_pend arriving during CHECK is serviced on the next IDLE cycle.

Test Plan:
- err held 2 cycles, then released with left=1, chk_ack tied high, hit=0: X goes 4→3 two edges after release; Y=0, rot=0.
- Rotate from rot=3 with ROT_STATES=4, hit=0 → rot=0. Rotate with hit=1 → rot stays 3, busy high for exactly the CHECK duration.
- X=0 with left=1 → no chk_req, X stays 0. X=9 with right=1 → no chk_req, X stays 9.
- Drop at Y=5 with hit=1 → lock_pulse high 1 cycle with Y=5, then Y=0, X=4, rot=0; spawn check hit=0 → busy=0.
- Spawn check hit=1 → game_over=1 persists 100 cycles despite toggling drop/left/right/ro; err → game_over=0, X=4, Y=0.
- GRAV_DIV=8, no inputs, hit=0: Y increments once every 8 cycles. err asserted while chk_req=1 → chk_req low next cycle, position back at spawn.

Source files
------------

// File: rtl/piece_ctrl.sv
// Active-piece controller: tracks the falling piece's anchor and rotation,
// arbitrates player commands against gravity, and sequences check/lock/spawn/game-over.
module piece_ctrl #(
  parameter int X_W        = 5,
  parameter int Y_W        = 5,
  parameter int ROT_W      = 2,
  parameter int ROT_STATES = 4,
  parameter int BOARD_W    = 10,
  parameter int BOARD_H    = 20,
  parameter int SPAWN_X    = 4,
  parameter int SPAWN_Y    = 0,
  parameter int GRAV_DIV   = 50000000
) (
  input  logic             clk,
  input  logic             err,
  input  logic             drop,
  input  logic             left,
  input  logic             right,
  input  logic             ro,
  input  logic             chk_ack,
  input  logic             chk_hit,
  output logic [X_W-1:0]   block_pos_x_out,
  output logic [Y_W-1:0]   block_pos_y_out,
  output logic [ROT_W-1:0] rotate,
  output logic             chk_req,
  output logic [X_W-1:0]   cand_x,
  output logic [Y_W-1:0]   cand_y,
  output logic [ROT_W-1:0] cand_rot,
  output logic             busy,
  output logic             lock_pulse,
  output logic             game_over
);

  localparam int CNT_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
  localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAV_DIV - 1);
  localparam logic [X_W-1:0]   X_MAX     = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(BOARD_H - 1);
  localparam logic [X_W-1:0]   X_SPAWN   = X_W'(SPAWN_X);
  localparam logic [Y_W-1:0]   Y_SPAWN   = Y_W'(SPAWN_Y);
  localparam logic [ROT_W-1:0] ROT_LAST  = ROT_W'(ROT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOCK, S_SPAWN, S_OVER} state_e;

  state_e           state_q, state_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d, cand_x_q, cand_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d, cand_y_q, cand_y_d;
  logic [ROT_W-1:0] rot_q, rot_d, cand_rot_q, cand_rot_d;
  logic             is_drop_q, is_drop_d;
  logic             grav_pend_q, grav_pend_d;
  logic [CNT_W-1:0] grav_cnt_q;
  logic             grav_wrap;
  logic             drop_launch;

  assign grav_wrap = (state_q != S_OVER) && (grav_cnt_q == GRAV_LAST);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    rot_d       = rot_q;
    cand_x_d    = cand_x_q;
    cand_y_d    = cand_y_q;
    cand_rot_d  = cand_rot_q;
    is_drop_d   = is_drop_q;
    drop_launch = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Candidate mirrors the committed piece; only the moved field differs.
        cand_x_d   = pos_x_q;
        cand_y_d   = pos_y_q;
        cand_rot_d = rot_q;
        if (drop || grav_pend_q) begin
          drop_launch = 1'b1;
          if (pos_y_q == Y_MAX) begin
            state_d = S_LOCK;
          end else begin
            cand_y_d  = pos_y_q + Y_W'(1);
            is_drop_d = 1'b1;
            state_d   = S_CHECK;
          end
        end else if (left) begin
          if (pos_x_q != '0) begin
            cand_x_d  = pos_x_q - X_W'(1);
            is_drop_d = 1'b0;
            state_d   = S_CHECK;
          end
        end else if (right) begin
          if (pos_x_q != X_MAX) begin
            cand_x_d  = pos_x_q + X_W'(1);
            is_drop_d = 1'b0;
            state_d   = S_CHECK;
          end
        end else if (ro) begin
          cand_rot_d = (rot_q == ROT_LAST) ? '0 : rot_q + ROT_W'(1);
          is_drop_d  = 1'b0;
          state_d    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk_ack) begin
          if (!chk_hit) begin
            pos_x_d = cand_x_q;
            pos_y_d = cand_y_q;
            rot_d   = cand_rot_q;
            state_d = S_IDLE;
          end else begin
            state_d = is_drop_q ? S_LOCK : S_IDLE;
          end
        end
      end
      S_LOCK: begin
        pos_x_d    = X_SPAWN;
        pos_y_d    = Y_SPAWN;
        rot_d      = '0;
        cand_x_d   = X_SPAWN;
        cand_y_d   = Y_SPAWN;
        cand_rot_d = '0;
        state_d    = S_SPAWN;
      end
      S_SPAWN: begin
        if (chk_ack) state_d = chk_hit ? S_OVER : S_IDLE;
      end
      S_OVER:  state_d = S_OVER;
      default: state_d = S_IDLE;
    endcase

    // A drop launched on the wrap cycle absorbs that gravity tick.
    if (drop_launch)    grav_pend_d = 1'b0;
    else if (grav_wrap) grav_pend_d = 1'b1;
    else                grav_pend_d = grav_pend_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (err) begin
      state_q     <= S_IDLE;
      pos_x_q     <= X_SPAWN;
      pos_y_q     <= Y_SPAWN;
      rot_q       <= '0;
      cand_x_q    <= X_SPAWN;
      cand_y_q    <= Y_SPAWN;
      cand_rot_q  <= '0;
      is_drop_q   <= 1'b0;
      grav_pend_q <= 1'b0;
      grav_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      rot_q       <= rot_d;
      cand_x_q    <= cand_x_d;
      cand_y_q    <= cand_y_d;
      cand_rot_q  <= cand_rot_d;
      is_drop_q   <= is_drop_d;
      grav_pend_q <= grav_pend_d;
      if (state_q != S_OVER) grav_cnt_q <= grav_wrap ? '0 : grav_cnt_q + CNT_W'(1);
    end
  end

  assign block_pos_x_out = pos_x_q;
  assign block_pos_y_out = pos_y_q;
  assign rotate          = rot_q;
  assign cand_x          = cand_x_q;
  assign cand_y          = cand_y_q;
  assign cand_rot        = cand_rot_q;
  assign chk_req         = (state_q == S_CHECK) || (state_q == S_SPAWN);
  assign busy            = (state_q != S_IDLE);
  assign lock_pulse      = (state_q == S_LOCK);
  assign game_over       = (state_q == S_OVER);

endmodule

// File: tb/tb_piece_ctrl.sv
// Self-checking bench for piece_ctrl: directed stimulus pushes expected events
// into a scoreboard that a negedge monitor pops as the DUT presents them.
module tb_piece_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: gravity slow enough never to fire during the directed run.
  logic err, drop, left, right, ro, chk_ack, chk_hit;
  logic [4:0] x, y, cx, cy;
  logic [1:0] r, cr;
  logic chk_req, busy, lock_pulse, game_over;

  piece_ctrl #(.GRAV_DIV(4096)) dut (
    .clk(clk), .err(err), .drop(drop), .left(left), .right(right), .ro(ro),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .block_pos_x_out(x), .block_pos_y_out(y), .rotate(r),
    .chk_req(chk_req), .cand_x(cx), .cand_y(cy), .cand_rot(cr),
    .busy(busy), .lock_pulse(lock_pulse), .game_over(game_over)
  );

  // Gravity instance with a short period.
  logic g_err, g_ack;
  logic [4:0] g_x, g_y, g_cx, g_cy;
  logic [1:0] g_r, g_cr;
  logic g_req, g_busy, g_lock, g_over;
  logic zero = 1'b0;

  piece_ctrl #(.GRAV_DIV(8)) dut_grav (
    .clk(clk), .err(g_err), .drop(zero), .left(zero), .right(zero), .ro(zero),
    .chk_ack(g_ack), .chk_hit(zero),
    .block_pos_x_out(g_x), .block_pos_y_out(g_y), .rotate(g_r),
    .chk_req(g_req), .cand_x(g_cx), .cand_y(g_cy), .cand_rot(g_cr),
    .busy(g_busy), .lock_pulse(g_lock), .game_over(g_over)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef enum int {EV_POS, EV_REQ, EV_LOCK} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int x;
    int y;
    int r;
  } exp_t;
  exp_t sb_q[$];

  task automatic push(input ev_kind_e k, input int ex, input int ey, input int er);
    exp_t e;
    e.kind = k; e.x = ex; e.y = ey; e.r = er;
    sb_q.push_back(e);
  endtask

  task automatic sb_compare(input ev_kind_e k, input int ax, input int ay, input int ar);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected: got %s (%0d,%0d,%0d) expected no event", k.name(), ax, ay, ar);
    end else begin
      e = sb_q.pop_front();
      check("sb_kind", int'(k), int'(e.kind));
      check($sformatf("%s_x", e.kind.name()), ax, e.x);
      check($sformatf("%s_y", e.kind.name()), ay, e.y);
      check($sformatf("%s_rot", e.kind.name()), ar, e.r);
    end
  endtask

  // Monitor: events in a cycle are taken in the order position, request, lock.
  initial begin
    int px, py, pr;
    logic preq;
    px = 0; py = 0; pr = 0; preq = 1'b0;
    forever begin
      @(negedge clk);
      if (err === 1'b0) begin
        if (int'(x) != px || int'(y) != py || int'(r) != pr) sb_compare(EV_POS, x, y, r);
        if (chk_req && !preq) sb_compare(EV_REQ, cx, cy, cr);
        if (lock_pulse) sb_compare(EV_LOCK, x, y, r);
      end
      px = x; py = y; pr = r; preq = chk_req;
    end
  end

  // Inputs change just after the negedge, well clear of the sampling posedge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    err = 1'b1; drop = 0; left = 0; right = 0; ro = 0; chk_ack = 0; chk_hit = 0;
    g_err = 1'b1; g_ack = 1'b1;

    // Reset held two cycles, then one left move with ack tied high.
    tick(); tick();
    check("rst_x", x, 4);      check("rst_y", y, 0);     check("rst_rot", r, 0);
    check("rst_busy", busy, 0); check("rst_req", chk_req, 0);
    check("rst_lock", lock_pulse, 0); check("rst_over", game_over, 0);
    check("rst_cand_x", cx, 4);
    err = 0; left = 1; chk_ack = 1; chk_hit = 0;
    push(EV_REQ, 3, 0, 0); push(EV_POS, 3, 0, 0);
    tick();
    check("left_x_edge1", x, 4); check("left_busy", busy, 1);
    tick();
    check("left_x_edge2", x, 3); check("left_y", y, 0); check("left_rot", r, 0);

    // Walk to the left wall, then push against it.
    for (int k = 2; k >= 0; k--) begin
      push(EV_REQ, k, 0, 0); push(EV_POS, k, 0, 0);
    end
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lwall_req", chk_req, 0);
    end
    check("lwall_x", x, 0);

    // Walk to the right wall, then push against it.
    left = 0; right = 1;
    for (int k = 1; k <= 9; k++) begin
      push(EV_REQ, k, 0, 0); push(EV_POS, k, 0, 0);
    end
    repeat (18) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rwall_req", chk_req, 0);
    end
    check("rwall_x", x, 9);

    // Rotate up to 3, then a rejected rotate with a stalled ack, then wrap to 0.
    right = 0; ro = 1;
    for (int k = 1; k <= 3; k++) begin
      push(EV_REQ, 9, 0, k); push(EV_POS, 9, 0, k);
    end
    repeat (6) tick();
    check("rot_three", r, 3);
    chk_ack = 0;
    push(EV_REQ, 9, 0, 0);
    tick();
    ro = 0;
    check("rothit_busy1", busy, 1); check("rothit_req", chk_req, 1);
    tick();
    check("rothit_busy2", busy, 1);
    chk_ack = 1; chk_hit = 1;
    tick();
    check("rothit_busy_end", busy, 0); check("rothit_rot", r, 3);
    chk_hit = 0; ro = 1;
    push(EV_REQ, 9, 0, 0); push(EV_POS, 9, 0, 0);
    tick();
    ro = 0;
    tick();
    check("rot_wrap", r, 0);

    // Soft-drop to Y=5, then a colliding drop: lock, respawn, clean spawn check.
    drop = 1;
    for (int k = 1; k <= 5; k++) begin
      push(EV_REQ, 9, k, 0); push(EV_POS, 9, k, 0);
    end
    repeat (10) tick();
    check("drop_y5", y, 5);
    chk_hit = 1;
    push(EV_REQ, 9, 6, 0); push(EV_LOCK, 9, 5, 0);
    push(EV_POS, 4, 0, 0); push(EV_REQ, 4, 0, 0);
    tick();
    drop = 0;
    check("dhit_req", chk_req, 1);
    tick();
    check("dhit_lock", lock_pulse, 1); check("dhit_lock_y", y, 5);
    chk_hit = 0;
    tick();
    check("spawn_lock_low", lock_pulse, 0); check("spawn_x", x, 4);
    check("spawn_y", y, 0); check("spawn_req", chk_req, 1);
    tick();
    check("spawn_busy", busy, 0);

    // Drop to the floor row, then drop again: lock without a check, spawn collides.
    drop = 1;
    for (int k = 1; k <= 19; k++) begin
      push(EV_REQ, 4, k, 0); push(EV_POS, 4, k, 0);
    end
    repeat (38) tick();
    check("floor_y", y, 19);
    push(EV_LOCK, 4, 19, 0); push(EV_POS, 4, 0, 0); push(EV_REQ, 4, 0, 0);
    tick();
    check("floor_lock", lock_pulse, 1); check("floor_noreq", chk_req, 0);
    drop = 0; chk_hit = 1;
    tick();
    check("over_spawn_req", chk_req, 1);
    tick();
    check("over_flag", game_over, 1); check("over_req", chk_req, 0);

    // Game over must hold against arbitrary input activity.
    for (int i = 0; i < 100; i++) begin
      drop = i[0]; left = i[1]; right = i[2]; ro = i[3];
      chk_ack = i[4]; chk_hit = i[1];
      tick();
      check("over_hold", game_over, 1);
      check("over_y_frozen", y, 0);
    end
    drop = 0; left = 0; right = 0; ro = 0; chk_ack = 1; chk_hit = 0;
    err = 1;
    tick();
    check("over_clr", game_over, 0); check("over_clr_x", x, 4);
    check("over_clr_y", y, 0); check("over_clr_busy", busy, 0);
    err = 0;
    tick(); tick();
    check("sb_drained", sb_q.size(), 0);

    // Gravity: one Y step every 8 cycles with ack tied high.
    g_err = 0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      check($sformatf("grav_y_c%0d", k), g_y, (k < 10) ? 0 : (k - 10) / 8 + 1);
    end
    g_ack = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (g_req) found = 1;
    end
    check("grav_req_seen", found, 1);
    g_err = 1;
    g_ack = 1;
    tick();
    check("grav_err_req", g_req, 0); check("grav_err_y", g_y, 0);
    check("grav_err_x", g_x, 4); check("grav_err_busy", g_busy, 0);
    g_err = 0;
    tick();
    check("grav_late_ack_busy", g_busy, 0); check("grav_late_ack_y", g_y, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
